// File: rtl/beat_sequencer_pkg.sv
// Shared types and defaults for the beat sequencer and its debounce helper.
package beat_pkg;

  typedef enum logic [1:0] {
    B_HALT = 2'd0,
    B_W1   = 2'd1,
    B_W2   = 2'd2,
    B_W3   = 2'd3
  } beat_e;

  localparam int DEBOUNCE_DEF = 4;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/beat_sequencer_qd_debounce.sv
// Front-panel start button debounce: one start pulse per accepted press,
// re-armed only after the button has been seen released for DEBOUNCE samples.
module qd_debounce
  import beat_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic t3,
  input  logic clr,
  input  logic qd,
  output logic start
);

  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       armed_q, armed_d;
  logic       start_q, start_d;

  assign cnt_inc = cnt_q + 4'd1;

  // Count consecutive samples at the level we are waiting for: high while
  // armed (press), low while disarmed (release). Any other sample restarts.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    start_d = 1'b0;
    if (armed_q) begin
      if (qd) begin
        if (cnt_inc == DB_LIM) begin
          start_d = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (!qd) begin
        if (cnt_inc == DB_LIM) begin
          armed_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      start_q <= start_d;
    end
  end

  assign start = start_q;

endmodule

// File: rtl/beat_sequencer.sv
// Machine-cycle beat generator: drives w1/w2/w3 for the cpu controller,
// honours short/long/stop requests, owns run/halt and the cycle counter.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             run,
  output logic [CNT_W-1:0] cycles
);

  beat_e            state_q, state_d;
  beat_e            resume_q, resume_d;
  beat_e            beat_nxt;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             w1_q, w2_q, w3_q, run_q;
  logic             start;

  qd_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .t3   (t3),
    .clr  (clr),
    .qd   (qd),
    .start(start)
  );

  // Beat that would follow the current one; short beats long in W1.
  always_comb begin
    beat_nxt = B_HALT;
    case (state_q)
      B_W1:    beat_nxt = short ? B_W1 : B_W2;
      B_W2:    beat_nxt = long ? B_W3 : B_W1;
      B_W3:    beat_nxt = B_W1;
      default: beat_nxt = B_HALT;
    endcase
  end

  // Sequencing: a stop still completes the beat (and cycle count) but parks
  // the computed beat in the resume register so a restart continues there.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    cycles_d = cycles_q;
    if (state_q == B_HALT) begin
      if (start) begin
        state_d = resume_q;
      end
    end else begin
      if (beat_nxt == B_W1) begin
        cycles_d = cycles_q + CNT_W'(1);
      end
      if (stop) begin
        resume_d = beat_nxt;
        state_d  = B_HALT;
      end else begin
        state_d = beat_nxt;
      end
    end
  end

  // State, resume, counter and registered beat decodes.
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state_q  <= B_HALT;
      resume_q <= B_W1;
      cycles_q <= '0;
      w1_q     <= 1'b0;
      w2_q     <= 1'b0;
      w3_q     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cycles_q <= cycles_d;
      w1_q     <= (state_d == B_W1);
      w2_q     <= (state_d == B_W2);
      w3_q     <= (state_d == B_W3);
      run_q    <= (state_d != B_HALT);
    end
  end

  assign w1     = w1_q;
  assign w2     = w2_q;
  assign w3     = w3_q;
  assign run    = run_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed test-plan steps followed by
// randomized traffic, compared against a behavioural model every edge. A
// second instance with a 2-bit counter shares the stimulus to exercise wrap.
module tb_beat_sequencer;

  localparam int DB = 4;

  logic       t3 = 1'b0;
  logic       clr = 1'b1;
  logic       qd = 1'b0;
  logic       short_i = 1'b0;
  logic       long_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       w1, w2, w3, run;
  logic [7:0] cycles;
  logic       w1_b, w2_b, w3_b, run_b;
  logic [1:0] cycles_b;

  beat_sequencer #(.DEBOUNCE(DB), .CNT_W(8)) dut (
    .t3(t3), .clr(clr), .qd(qd), .short(short_i), .long(long_i), .stop(stop_i),
    .w1(w1), .w2(w2), .w3(w3), .run(run), .cycles(cycles)
  );

  beat_sequencer #(.DEBOUNCE(DB), .CNT_W(2)) dut_w (
    .t3(t3), .clr(clr), .qd(qd), .short(short_i), .long(long_i), .stop(stop_i),
    .w1(w1_b), .w2(w2_b), .w3(w3_b), .run(run_b), .cycles(cycles_b)
  );

  always #5 t3 = ~t3;

  int checks = 0;
  int errors = 0;

  // Behavioural model: beat number 0 = halted, 1..3 = W1..W3.
  int m_beat, m_resume, m_cycles, m_streak;
  bit m_armed, m_start;
  int starts;

  task automatic model_reset();
    m_beat   = 0;
    m_resume = 1;
    m_cycles = 0;
    m_streak = 0;
    m_armed  = 1;
    m_start  = 0;
  endtask

  task automatic model_step();
    bit s;
    int nb;
    s = m_start;
    if (m_beat != 0) begin
      if (m_beat == 1)      nb = short_i ? 1 : 2;
      else if (m_beat == 2) nb = long_i ? 3 : 1;
      else                  nb = 1;
      if (nb == 1) m_cycles = m_cycles + 1;
      if (stop_i) begin
        m_resume = nb;
        m_beat   = 0;
      end else begin
        m_beat = nb;
      end
    end else if (s) begin
      m_beat = m_resume;
    end
    m_start = 0;
    if (m_armed) begin
      if (qd) begin
        m_streak++;
        if (m_streak == DB) begin
          m_start  = 1;
          m_armed  = 0;
          m_streak = 0;
        end
      end else m_streak = 0;
    end else begin
      if (!qd) begin
        m_streak++;
        if (m_streak == DB) begin
          m_armed  = 1;
          m_streak = 0;
        end
      end else m_streak = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w1", 32'(w1), 32'(m_beat == 1));
    chk("w2", 32'(w2), 32'(m_beat == 2));
    chk("w3", 32'(w3), 32'(m_beat == 3));
    chk("run", 32'(run), 32'(m_beat != 0));
    chk("cycles", 32'(cycles), 32'(m_cycles % 256));
    chk("cycles_w2", 32'(cycles_b), 32'(m_cycles % 4));
    chk("run_w2", 32'(run_b), 32'(m_beat != 0));
  endtask

  task automatic tick();
    @(posedge t3);
    model_step();
    #1;
    check_all();
  endtask

  // Called one time unit after a rising edge: drop clr mid-beat, check the
  // outputs clear without a clock, then release before the next edge.
  task automatic async_reset();
    #2;
    clr = 1'b0;
    #1;
    chk("async_w3", 32'(w3), 32'd0);
    chk("async_run", 32'(run), 32'd0);
    chk("async_cycles", 32'(cycles), 32'd0);
    model_reset();
    check_all();
    #1;
    clr = 1'b1;
  endtask

  task automatic drive_to_w2();
    for (int i = 0; i < 6 && m_beat != 2; i++) tick();
    chk("reach_w2", 32'(w2), 32'd1);
  endtask

  initial begin
    model_reset();
    #1 clr = 1'b0;
    #11;
    check_all();
    @(negedge t3) clr = 1'b1;

    // Reset then start: first beat after edge 5.
    qd = 1'b1;
    repeat (4) tick();
    chk("lat_pre_run", 32'(run), 32'd0);
    tick();
    chk("lat_w1", 32'(w1), 32'd1);
    tick();
    chk("lat_w2", 32'(w2), 32'd1);
    tick();
    chk("lat_cyc_w1", 32'(w1), 32'd1);
    chk("lat_cycles", 32'(cycles), 32'd1);
    qd = 1'b0;

    // Short in W1 repeats W1, long in W2 inserts W3.
    short_i = 1'b1;
    repeat (4) tick();
    chk("short_cycles", 32'(cycles), 32'd5);
    short_i = 1'b0;
    long_i = 1'b1;
    repeat (6) tick();
    long_i = 1'b0;

    // Stop during W2 with long parks W3; a new press resumes there.
    drive_to_w2();
    long_i = 1'b1;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    long_i = 1'b0;
    chk("stop_run", 32'(run), 32'd0);
    repeat (5) tick();
    qd = 1'b1;
    repeat (5) tick();
    chk("resume_w3", 32'(w3), 32'd1);
    qd = 1'b0;
    tick();
    chk("after_w3_w1", 32'(w1), 32'd1);

    // Debounce: with stop held each start yields a single beat.
    stop_i = 1'b1;
    tick();
    qd = 1'b1;
    repeat (3) tick();
    qd = 1'b0;
    starts = 0;
    repeat (5) begin tick(); if (run) starts++; end
    chk("glitch_no_start", 32'(starts), 32'd0);
    qd = 1'b1;
    starts = 0;
    repeat (40) begin tick(); if (run) starts++; end
    chk("held_one_start", 32'(starts), 32'd1);
    qd = 1'b0;
    repeat (4) tick();
    qd = 1'b1;
    starts = 0;
    repeat (6) begin tick(); if (run) starts++; end
    chk("second_start", 32'(starts), 32'd1);
    stop_i = 1'b0;
    qd = 1'b0;
    repeat (4) tick();

    // Counter wrap on the 2-bit instance via short cycles.
    qd = 1'b1;
    repeat (5) tick();
    qd = 1'b0;
    for (int i = 0; i < 4 && m_beat != 1; i++) tick();
    short_i = 1'b1;
    repeat (5) tick();
    short_i = 1'b0;

    // Park W3, resume into it, reset mid-W3; next start must be W1.
    drive_to_w2();
    long_i = 1'b1;
    stop_i = 1'b1;
    tick();
    long_i = 1'b0;
    stop_i = 1'b0;
    repeat (4) tick();
    qd = 1'b1;
    repeat (5) tick();
    chk("pre_rst_w3", 32'(w3), 32'd1);
    qd = 1'b0;
    async_reset();
    repeat (2) tick();
    qd = 1'b1;
    repeat (5) tick();
    chk("post_rst_w1", 32'(w1), 32'd1);
    qd = 1'b0;

    // Randomized traffic.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) qd = ~qd;
      short_i = ($urandom_range(0, 3) == 0);
      long_i  = ($urandom_range(0, 2) == 0);
      stop_i  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
